// File: rtl/pc_link_arbiter.sv
// pc_link_arbiter
//   Shares the single PC UART byte link between the MSP handler and the
//   BLHeli/ESC serial passthrough path.
//   MSP mode      : PC RX -> msp_rx, msp_tx -> PC TX.
//   DRAIN         : PC RX -> esc_rx, msp_tx still owns PC TX until its
//                   residual reply byte has gone out.
//   PASSTHROUGH   : PC RX -> esc_rx, esc_tx -> PC TX, idle timeout armed.
//   EXIT          : one-cycle pt_exit pulse, then back to MSP mode.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   pc_rx_data/valid              byte strobe from UART RX
//   pc_tx_data/valid/ready        byte handshake to UART TX
//   msp_rx_data/valid             byte strobe to msp_handler
//   msp_tx_data/valid/ready       reply handshake from msp_handler
//   pt_req, pt_motor, pt_abort    passthrough entry request / ESC index / abort
//   esc_rx_data/valid             byte strobe to ESC serial engine
//   esc_tx_data/valid/ready       byte handshake from ESC serial engine
//   esc_sel                       selected ESC channel
//   passthrough                   high in DRAIN and PASSTHROUGH
//   pt_exit                       one-cycle pulse on return to MSP mode
module pc_link_arbiter #(
  parameter int CLK_FREQ_HZ     = 72_000_000,
  parameter int IDLE_TIMEOUT_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pc_rx_data,
  input  logic       pc_rx_valid,
  output logic [7:0] pc_tx_data,
  output logic       pc_tx_valid,
  input  logic       pc_tx_ready,
  output logic [7:0] msp_rx_data,
  output logic       msp_rx_valid,
  input  logic [7:0] msp_tx_data,
  input  logic       msp_tx_valid,
  output logic       msp_tx_ready,
  input  logic       pt_req,
  input  logic [1:0] pt_motor,
  input  logic       pt_abort,
  output logic [7:0] esc_rx_data,
  output logic       esc_rx_valid,
  input  logic [7:0] esc_tx_data,
  input  logic       esc_tx_valid,
  output logic       esc_tx_ready,
  output logic [1:0] esc_sel,
  output logic       passthrough,
  output logic       pt_exit
);

  localparam int IDLE_CYCLES = (CLK_FREQ_HZ / 1000) * IDLE_TIMEOUT_MS;
  localparam int CW          = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_MSP   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PT    = 2'd2,
    ST_EXIT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]    esc_sel_q, esc_sel_d;
  logic [7:0]    rx_data_q;
  logic          msp_rx_vld_q, esc_rx_vld_q;
  logic          passthrough_q, pt_exit_q;

  logic rx_to_esc, tx_from_esc, esc_hs, activity;

  // Routing is decided by the current state, so a byte arriving together
  // with pt_req still goes to MSP and one arriving with pt_abort still goes
  // to the ESC.
  assign rx_to_esc   = (state_q == ST_DRAIN) || (state_q == ST_PT);
  assign tx_from_esc = (state_q == ST_PT);
  assign esc_hs      = tx_from_esc & esc_tx_valid & pc_tx_ready;
  assign activity    = pc_rx_valid | esc_hs;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    esc_sel_d  = esc_sel_q;
    unique case (state_q)
      ST_MSP: begin
        if (pt_req) begin
          esc_sel_d = pt_motor;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pt_abort) begin
          state_d = ST_EXIT;
        end else if (!msp_tx_valid) begin
          state_d    = ST_PT;
          idle_cnt_d = '0;
        end
      end
      ST_PT: begin
        // Abort wins over both activity and the timeout.
        if (pt_abort) begin
          state_d = ST_EXIT;
        end else if (activity) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = ST_EXIT;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_EXIT: begin
        state_d    = ST_MSP;
        idle_cnt_d = '0;
      end
      default: state_d = ST_MSP;
    endcase
  end

  // Registered RX strobes and mode flags; flags follow the next state so
  // they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_MSP;
      idle_cnt_q    <= '0;
      esc_sel_q     <= '0;
      rx_data_q     <= '0;
      msp_rx_vld_q  <= 1'b0;
      esc_rx_vld_q  <= 1'b0;
      passthrough_q <= 1'b0;
      pt_exit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      esc_sel_q     <= esc_sel_d;
      if (pc_rx_valid) rx_data_q <= pc_rx_data;
      msp_rx_vld_q  <= pc_rx_valid & ~rx_to_esc;
      esc_rx_vld_q  <= pc_rx_valid & rx_to_esc;
      passthrough_q <= (state_d == ST_DRAIN) || (state_d == ST_PT);
      pt_exit_q     <= (state_d == ST_EXIT);
    end
  end

  assign msp_rx_data  = rx_data_q;
  assign msp_rx_valid = msp_rx_vld_q;
  assign esc_rx_data  = rx_data_q;
  assign esc_rx_valid = esc_rx_vld_q;
  assign esc_sel      = esc_sel_q;
  assign passthrough  = passthrough_q;
  assign pt_exit      = pt_exit_q;

  // TX mux is combinational; reset forces the pass-through outputs low so
  // the whole port reads idle while rst is held.
  assign pc_tx_valid  = ~rst & (tx_from_esc ? esc_tx_valid : msp_tx_valid);
  assign pc_tx_data   = rst ? 8'h00 : (tx_from_esc ? esc_tx_data : msp_tx_data);
  assign msp_tx_ready = ~rst & ~tx_from_esc & pc_tx_ready;
  assign esc_tx_ready = ~rst & tx_from_esc & pc_tx_ready;

endmodule

// File: tb/tb_pc_link_arbiter.sv
module tb_pc_link_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] pc_rx_data;
  logic       pc_rx_valid;
  logic [7:0] pc_tx_data;
  logic       pc_tx_valid;
  logic       pc_tx_ready;
  logic [7:0] msp_rx_data;
  logic       msp_rx_valid;
  logic [7:0] msp_tx_data;
  logic       msp_tx_valid;
  logic       msp_tx_ready;
  logic       pt_req;
  logic [1:0] pt_motor;
  logic       pt_abort;
  logic [7:0] esc_rx_data;
  logic       esc_rx_valid;
  logic [7:0] esc_tx_data;
  logic       esc_tx_valid;
  logic       esc_tx_ready;
  logic [1:0] esc_sel;
  logic       passthrough;
  logic       pt_exit;

  pc_link_arbiter #(.CLK_FREQ_HZ(1000), .IDLE_TIMEOUT_MS(20)) dut (
    .clk(clk), .rst(rst),
    .pc_rx_data(pc_rx_data), .pc_rx_valid(pc_rx_valid),
    .pc_tx_data(pc_tx_data), .pc_tx_valid(pc_tx_valid), .pc_tx_ready(pc_tx_ready),
    .msp_rx_data(msp_rx_data), .msp_rx_valid(msp_rx_valid),
    .msp_tx_data(msp_tx_data), .msp_tx_valid(msp_tx_valid), .msp_tx_ready(msp_tx_ready),
    .pt_req(pt_req), .pt_motor(pt_motor), .pt_abort(pt_abort),
    .esc_rx_data(esc_rx_data), .esc_rx_valid(esc_rx_valid),
    .esc_tx_data(esc_tx_data), .esc_tx_valid(esc_tx_valid), .esc_tx_ready(esc_tx_ready),
    .esc_sel(esc_sel), .passthrough(passthrough), .pt_exit(pt_exit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        to_esc;
    logic [7:0]  data;
    logic [31:0] cyc;
  } rx_exp_t;

  rx_exp_t rx_q[$];

  int drv_cmp = 0, drv_fail = 0;
  int mon_cmp = 0, mon_fail = 0;

  // Monitor: every RX strobe must match the oldest expected byte, on the
  // right destination and exactly one cycle after it was driven.
  always @(negedge clk) begin
    rx_exp_t e;
    if (msp_rx_valid || esc_rx_valid) begin
      mon_cmp = mon_cmp + 1;
      if (msp_rx_valid && esc_rx_valid) begin
        mon_fail = mon_fail + 1;
        $display("FAIL rx_both: msp_rx_valid=1 esc_rx_valid=1, required only one");
      end else if (rx_q.size() == 0) begin
        mon_fail = mon_fail + 1;
        $display("FAIL rx_unexpected: got strobe esc=%0b data=%02h, required none",
                 esc_rx_valid, esc_rx_valid ? esc_rx_data : msp_rx_data);
      end else begin
        e = rx_q.pop_front();
        if (esc_rx_valid !== e.to_esc ||
            (esc_rx_valid ? esc_rx_data : msp_rx_data) !== e.data ||
            cyc !== e.cyc) begin
          mon_fail = mon_fail + 1;
          $display("FAIL rx_byte: got esc=%0b data=%02h cyc=%0d, required esc=%0b data=%02h cyc=%0d",
                   esc_rx_valid, esc_rx_valid ? esc_rx_data : msp_rx_data, cyc,
                   e.to_esc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    drv_cmp = drv_cmp + 1;
    if (act !== exp) begin
      drv_fail = drv_fail + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pc(input logic [7:0] b, input logic to_esc);
    rx_exp_t e;
    e.to_esc = to_esc;
    e.data   = b;
    e.cyc    = cyc + 1;
    rx_q.push_back(e);
    pc_rx_data  = b;
    pc_rx_valid = 1'b1;
    tick();
    pc_rx_valid = 1'b0;
  endtask

  task automatic enter_pt(input logic [1:0] m);
    pt_req   = 1'b1;
    pt_motor = m;
    tick();
    pt_req = 1'b0;
    tick();
  endtask

  logic [7:0] msp_bytes [6];

  initial begin
    msp_bytes = '{8'h24, 8'h4D, 8'h3C, 8'h00, 8'h64, 8'h64};
    rst = 1'b1;
    pc_rx_data = 0; pc_rx_valid = 0; pc_tx_ready = 0;
    msp_tx_data = 0; msp_tx_valid = 0;
    pt_req = 0; pt_motor = 0; pt_abort = 0;
    esc_tx_data = 0; esc_tx_valid = 0;
    repeat (3) tick();
    chk("rst_passthrough", passthrough, 0);
    chk("rst_esc_sel", esc_sel, 0);
    chk("rst_pt_exit", pt_exit, 0);
    chk("rst_rx_valids", {msp_rx_valid, esc_rx_valid}, 0);
    rst = 1'b0;
    tick();

    // 1. MSP mode RX and TX.
    foreach (msp_bytes[i]) send_pc(msp_bytes[i], 1'b0);
    msp_tx_valid = 1; msp_tx_data = 8'h24; pc_tx_ready = 1;
    esc_tx_valid = 1; esc_tx_data = 8'h99;
    #1;
    chk("msp_tx_valid", pc_tx_valid, 1);
    chk("msp_tx_data", pc_tx_data, 8'h24);
    chk("msp_tx_ready", msp_tx_ready, 1);
    chk("esc_ready_in_msp", esc_tx_ready, 0);
    tick();
    esc_tx_valid = 0;

    // 2. Request while a reply byte is stalled: DRAIN holds.
    msp_tx_data = 8'h7E; msp_tx_valid = 1; pc_tx_ready = 0;
    pt_req = 1; pt_motor = 2;
    tick();
    pt_req = 0;
    chk("drain_passthrough", passthrough, 1);
    chk("drain_esc_sel", esc_sel, 2);
    chk("drain_tx_data", pc_tx_data, 8'h7E);
    chk("drain_msp_ready", msp_tx_ready, 0);
    send_pc(8'h3A, 1'b1);
    chk("drain_hold", passthrough, 1);
    pc_tx_ready = 1;
    #1;
    chk("drain_msp_ready_hi", msp_tx_ready, 1);
    tick();
    msp_tx_valid = 0;
    pc_tx_ready = 0;
    tick();

    // 3. PASSTHROUGH traffic.
    send_pc(8'hAA, 1'b1);
    send_pc(8'hBB, 1'b1);
    send_pc(8'hCC, 1'b1);
    esc_tx_valid = 1; esc_tx_data = 8'h55; msp_tx_valid = 1; msp_tx_data = 8'h11;
    #1;
    chk("pt_tx_valid", pc_tx_valid, 1);
    chk("pt_tx_data", pc_tx_data, 8'h55);
    chk("pt_esc_ready_lo", esc_tx_ready, 0);
    pc_tx_ready = 1;
    #1;
    chk("pt_esc_ready_hi", esc_tx_ready, 1);
    chk("pt_msp_ready", msp_tx_ready, 0);
    tick();
    esc_tx_valid = 0; msp_tx_valid = 0; pc_tx_ready = 0;

    // 4. Idle timeout of 20 cycles.
    repeat (19) tick();
    chk("idle19_passthrough", passthrough, 1);
    chk("idle19_pt_exit", pt_exit, 0);
    tick();
    chk("timeout_pt_exit", pt_exit, 1);
    chk("timeout_passthrough", passthrough, 0);
    chk("timeout_esc_sel", esc_sel, 2);
    tick();
    chk("exit_pulse_len", pt_exit, 0);
    send_pc(8'h24, 1'b0);

    // 4b. Byte on the terminal idle cycle restarts the count.
    enter_pt(2'd1);
    repeat (19) tick();
    send_pc(8'h77, 1'b1);
    chk("terminal_act_stay", passthrough, 1);
    chk("terminal_act_no_exit", pt_exit, 0);
    repeat (19) tick();
    chk("restart_idle19", passthrough, 1);
    tick();
    chk("restart_timeout", pt_exit, 1);
    tick();

    // 5. pt_req ignored in PASSTHROUGH; abort with a same-cycle byte.
    enter_pt(2'd3);
    pt_req = 1; pt_motor = 0;
    tick();
    pt_req = 0;
    tick();
    chk("pt_req_ignored_sel", esc_sel, 3);
    chk("pt_req_ignored_mode", passthrough, 1);
    pt_abort = 1;
    send_pc(8'hEE, 1'b1);
    pt_abort = 0;
    chk("abort_pt_exit", pt_exit, 1);
    chk("abort_passthrough", passthrough, 0);
    tick();
    chk("abort_back_msp", {passthrough, pt_exit}, 0);
    pt_abort = 1;
    tick();
    pt_abort = 0;
    chk("abort_in_msp_ignored", {passthrough, pt_exit}, 0);
    send_pc(8'h11, 1'b0);

    // 6. Asynchronous reset mid-PASSTHROUGH drops an in-flight byte.
    enter_pt(2'd2);
    esc_tx_valid = 1; esc_tx_data = 8'hA5; pc_tx_ready = 1;
    pc_rx_data = 8'h66; pc_rx_valid = 1;
    #2;
    rst = 1;
    #1;
    chk("arst_passthrough", passthrough, 0);
    chk("arst_esc_sel", esc_sel, 0);
    chk("arst_tx", {pc_tx_valid, pc_tx_data, esc_tx_ready, msp_tx_ready}, 0);
    chk("arst_rx", {msp_rx_valid, esc_rx_valid, msp_rx_data, esc_rx_data}, 0);
    pc_rx_valid = 0; esc_tx_valid = 0; pc_tx_ready = 0;
    tick();
    rst = 0;
    tick();
    send_pc(8'h5A, 1'b0);

    repeat (3) tick();
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             drv_cmp + mon_cmp, drv_fail + mon_fail);
    $finish;
  end

endmodule

// File: doc/pc_link_arbiter.md
Name: pc_link_arbiter

Overview:
Owns the single PC UART byte link and shares it between the MSP handler and the BLHeli/ESC serial passthrough path. In normal mode, PC bytes go to the MSP handler and MSP replies go back to the PC. After MSP_SET_PASSTHROUGH is acknowledged, the block switches the link to the selected ESC channel. It returns to MSP mode on an idle timeout or an explicit abort. It sits between the UART RX/TX byte interfaces, msp_handler, and the ESC serial engine.

Parameters:
CLK_FREQ_HZ, 72_000_000, system clock frequency in Hz.
IDLE_TIMEOUT_MS, 2000, passthrough exit after this many ms with no traffic.
Derived: IDLE_CYCLES = (CLK_FREQ_HZ/1000)*IDLE_TIMEOUT_MS. The idle counter is $clog2(IDLE_CYCLES+1) bits wide.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pc_rx_data  in  8  byte from UART RX
pc_rx_valid  in  1  one-cycle strobe, byte valid
pc_tx_data  out  8  byte to UART TX
pc_tx_valid  out  1  TX byte valid
pc_tx_ready  in  1  UART TX accepts byte
msp_rx_data  out  8  byte to msp_handler
msp_rx_valid  out  1  one-cycle strobe
msp_tx_data  in  8  reply byte from msp_handler
msp_tx_valid  in  1  reply byte valid
msp_tx_ready  out  1  reply byte accepted
pt_req  in  1  pulse from msp_handler after the SET_PASSTHROUGH reply checksum is accepted
pt_motor  in  2  ESC index, sampled with pt_req
pt_abort  in  1  force exit from passthrough
esc_rx_data  out  8  byte to ESC serial engine
esc_rx_valid  out  1  one-cycle strobe
esc_tx_data  in  8  byte from ESC
esc_tx_valid  in  1  ESC byte valid
esc_tx_ready  out  1  ESC byte accepted
esc_sel  out  2  selected ESC channel
passthrough  out  1  high in DRAIN and PASSTHROUGH
pt_exit  out  1  one-cycle pulse on return to MSP mode

Behaviour:
- Reset (async assert): state=MSP. All *_valid, *_data, esc_sel, passthrough, pt_exit and the idle counter go to 0. Reset mid-passthrough drops any in-flight byte and resumes MSP mode.
- RX path: registered, 1-cycle latency. pc_rx_valid at cycle N gives the destination strobe at N+1 with the same data. Exactly one destination strobes; the other stays 0. RX has no backpressure, so bytes are never dropped except during reset.
- TX path: combinational mux, zero latency.
  - pc_tx_valid/pc_tx_data come from the selected source.
  - Selected source ready = pc_tx_ready; the unselected source sees ready=0.
  - A transfer occurs when valid && ready.
- States:
  - MSP:
    - RX goes to msp_rx; TX source is msp_tx.
    - pt_req=1: latch esc_sel<=pt_motor and go to DRAIN. A pt_req arriving with pc_rx_valid still routes that byte to MSP.
  - DRAIN:
    - TX source is still msp_tx, so any residual reply byte completes.
    - RX goes to esc_rx.
    - When msp_tx_valid=0, go to PASSTHROUGH and load the idle counter with 0.
  - PASSTHROUGH:
    - RX goes to esc_rx; TX source is esc_tx; msp_tx_ready=0.
    - Activity = pc_rx_valid or an ESC TX handshake. Activity clears the idle counter; otherwise the counter increments.
    - Counter == IDLE_CYCLES-1 with no activity that cycle: go to EXIT.
    - Activity on the terminal cycle: clear the counter and stay.
    - pt_abort=1 from DRAIN or PASSTHROUGH: go to EXIT next cycle. pt_abort has priority over the timeout; a byte arriving in the same cycle is still forwarded to ESC.
  - EXIT (1 cycle):
    - pt_exit=1, passthrough=0, esc_sel held.
    - RX goes to msp_rx; TX source is msp_tx.
    - Next state is MSP.
- pt_req outside MSP is ignored. pt_abort in MSP or EXIT is ignored.
- passthrough is registered and asserted from the first DRAIN cycle.
- An ESC byte presented while the state is not PASSTHROUGH sees esc_tx_ready=0 and waits.

Test Plan:
Benches use CLK_FREQ_HZ=1000, IDLE_TIMEOUT_MS=20, so IDLE_CYCLES=20.
1. After reset, send the PC bytes 24 4D 3C 00 64 64 -> six msp_rx_valid strobes with identical data, each 1 cycle after its input; esc_rx_valid never asserted. Drive msp_tx_valid with byte 0x24 and pc_tx_ready=1 -> pc_tx_data=0x24 in the same cycle.
2. pt_req=1 with pt_motor=2 while msp_tx_valid=1 and pc_tx_ready=0 -> state stays DRAIN, passthrough=1, esc_sel=2. Raise pc_tx_ready -> byte transfers, msp_tx_valid drops, state enters PASSTHROUGH.
3. In PASSTHROUGH, PC sends AA BB CC -> esc_rx strobes AA BB CC, msp_rx_valid stays 0. ESC presents 0x55 -> pc_tx_data=0x55 and esc_tx_ready=pc_tx_ready.
4. Idle 20 cycles after the last activity -> pt_exit pulses for one cycle and passthrough=0. Next PC byte 0x24 goes to msp_rx. Variant: send a byte on the 20th idle cycle -> no exit, and the counter restarts.
5. pt_abort in PASSTHROUGH together with pc_rx_valid=0xEE -> 0xEE appears on esc_rx, followed by EXIT then MSP. pt_req asserted during PASSTHROUGH -> ignored and esc_sel unchanged.
6. Assert rst mid-PASSTHROUGH asynchronously, between clock edges -> all outputs read 0 immediately. After deassertion, the first PC byte goes to msp_rx.
